// File: rtl/program_loader_if.sv
// Bus bundle between the program loader and its surroundings.
//   Byte input side : RX_DATA, RX_VALID (from host), RX_READY (to host)
//   Control         : LOAD_REQ (restart pulse from host)
//   Memory write    : ADDR_W, ENABLE_W, Q_W (shaped like the RAM write port)
//   Core/status     : CORE_RESET_N, DONE, ERROR
// Modport master is the loader itself; modport slave is the host/memory side.
interface program_loader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int SIZE       = 32
);
  logic [7:0]            RX_DATA;
  logic                  RX_VALID;
  logic                  RX_READY;
  logic                  LOAD_REQ;
  logic [ADDR_WIDTH-1:0] ADDR_W;
  logic                  ENABLE_W;
  logic [SIZE-1:0]       Q_W;
  logic                  CORE_RESET_N;
  logic                  DONE;
  logic                  ERROR;

  modport master (
    input  RX_DATA, RX_VALID, LOAD_REQ,
    output RX_READY, ADDR_W, ENABLE_W, Q_W, CORE_RESET_N, DONE, ERROR
  );

  modport slave (
    output RX_DATA, RX_VALID, LOAD_REQ,
    input  RX_READY, ADDR_W, ENABLE_W, Q_W, CORE_RESET_N, DONE, ERROR
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader. Takes a framed byte stream
//   count_lo, count_hi, 4*N data bytes (LS byte first), XOR checksum byte
// assembles 32-bit little-endian words, writes each to instruction memory
// through ADDR_W/ENABLE_W/Q_W, and releases the core reset only once the
// checksum matched.
// Ports:
//   CLK      system clock, rising edge
//   RESET_N  asynchronous active-low reset
//   bus      program_loader_if.master (byte input, write port, status)
module program_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int SIZE       = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  program_loader_if.master  bus
);

  typedef enum logic [2:0] {
    ST_HDR_LO,
    ST_HDR_HI,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  // Largest accepted word count; one extra counter bit lets it be represented.
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  state_t                state_reg;
  logic [15:0]           count_reg;
  logic [1:0]            byte_cnt_reg;
  logic [ADDR_WIDTH:0]   word_cnt_reg;
  logic [7:0]            csum_reg;
  logic [23:0]           asm_reg;      // lanes 0..2; lane 3 goes straight to Q_W
  logic [ADDR_WIDTH-1:0] addr_w_reg;
  logic [SIZE-1:0]       q_w_reg;
  logic                  enable_w_reg;
  logic                  rx_ready_reg;
  logic                  core_reset_n_reg;
  logic                  done_reg;
  logic                  error_reg;

  logic                  accept;
  logic [15:0]           hdr_count;
  logic [ADDR_WIDTH:0]   word_cnt_inc;

  assign accept       = bus.RX_VALID & rx_ready_reg;
  assign hdr_count    = {bus.RX_DATA, count_reg[7:0]};
  assign word_cnt_inc = word_cnt_reg + 1'b1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg        <= ST_HDR_LO;
      count_reg        <= '0;
      byte_cnt_reg     <= '0;
      word_cnt_reg     <= '0;
      csum_reg         <= '0;
      asm_reg          <= '0;
      addr_w_reg       <= '0;
      q_w_reg          <= '0;
      enable_w_reg     <= 1'b0;
      rx_ready_reg     <= 1'b0;
      core_reset_n_reg <= 1'b0;
      done_reg         <= 1'b0;
      error_reg        <= 1'b0;
    end else begin
      // Write strobe is a single-cycle pulse unless re-armed below.
      enable_w_reg <= 1'b0;

      case (state_reg)
        ST_HDR_LO: begin
          rx_ready_reg <= 1'b1;
          if (accept) begin
            count_reg[7:0] <= bus.RX_DATA;
            state_reg      <= ST_HDR_HI;
          end
        end

        ST_HDR_HI: begin
          rx_ready_reg <= 1'b1;
          if (accept) begin
            count_reg[15:8] <= bus.RX_DATA;
            if ({1'b0, hdr_count} > MAX_WORDS) begin
              state_reg    <= ST_ERR;
              error_reg    <= 1'b1;
              rx_ready_reg <= 1'b0;
            end else if (hdr_count == 16'd0) begin
              state_reg <= ST_CHECK;
            end else begin
              state_reg <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          rx_ready_reg <= 1'b1;
          if (accept) begin
            csum_reg     <= csum_reg ^ bus.RX_DATA;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
            case (byte_cnt_reg)
              2'd0: asm_reg[7:0]   <= bus.RX_DATA;
              2'd1: asm_reg[15:8]  <= bus.RX_DATA;
              2'd2: asm_reg[23:16] <= bus.RX_DATA;
              default: begin
                // Word complete: issue the write next cycle while the
                // following word keeps streaming in.
                enable_w_reg <= 1'b1;
                q_w_reg      <= SIZE'({bus.RX_DATA, asm_reg});
                addr_w_reg   <= word_cnt_reg[ADDR_WIDTH-1:0];
                word_cnt_reg <= word_cnt_inc;
                if (16'(word_cnt_inc) == count_reg) begin
                  state_reg <= ST_CHECK;
                end
              end
            endcase
          end
        end

        ST_CHECK: begin
          rx_ready_reg <= 1'b1;
          if (accept) begin
            rx_ready_reg <= 1'b0;
            if (bus.RX_DATA == csum_reg) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_ERR;
              error_reg <= 1'b1;
            end
          end
        end

        ST_DONE: begin
          // Entered at least one cycle after the final write strobe, so the
          // core never sees reset release alongside a memory write.
          rx_ready_reg     <= 1'b0;
          core_reset_n_reg <= 1'b1;
        end

        default: begin // ST_ERR
          rx_ready_reg     <= 1'b0;
          core_reset_n_reg <= 1'b0;
        end
      endcase

      // Restart overrides everything in the terminal states; ADDR_W/Q_W
      // keep their last written value.
      if (bus.LOAD_REQ && (state_reg == ST_DONE || state_reg == ST_ERR)) begin
        state_reg        <= ST_HDR_LO;
        count_reg        <= '0;
        byte_cnt_reg     <= '0;
        word_cnt_reg     <= '0;
        csum_reg         <= '0;
        asm_reg          <= '0;
        rx_ready_reg     <= 1'b1;
        core_reset_n_reg <= 1'b0;
        done_reg         <= 1'b0;
        error_reg        <= 1'b0;
      end
    end
  end

  assign bus.RX_READY     = rx_ready_reg;
  assign bus.ADDR_W       = addr_w_reg;
  assign bus.ENABLE_W     = enable_w_reg;
  assign bus.Q_W          = q_w_reg;
  assign bus.CORE_RESET_N = core_reset_n_reg;
  assign bus.DONE         = done_reg;
  assign bus.ERROR        = error_reg;

endmodule
